// File: rtl/memory_arbiter_if.sv
// Cache-side request/response and RAM-side bus bundle for memory_arbiter.
interface memory_arbiter_if;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;

    // Instruction port
    logic              iREN;
    logic [ADDR_W-1:0] iaddr;
    logic              ihit;
    logic [DATA_W-1:0] iload;

    // Data port
    logic              dREN;
    logic              dWEN;
    logic [ADDR_W-1:0] daddr;
    logic [DATA_W-1:0] dstore;
    logic              dhit;
    logic [DATA_W-1:0] dload;

    // RAM port
    logic              ramREN;
    logic              ramWEN;
    logic [ADDR_W-1:0] ramaddr;
    logic [DATA_W-1:0] ramstore;
    logic [DATA_W-1:0] ramload;
    logic [1:0]        ramstate;

    // Timeout abort pulse
    logic              err;

    // Arbiter side: serves the caches, masters the RAM.
    modport master (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        output ihit, iload, dhit, dload, ramREN, ramWEN, ramaddr, ramstore, err
    );

    // Environment side: caches plus RAM.
    modport slave (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        input  ihit, iload, dhit, dload, ramREN, ramWEN, ramaddr, ramstore, err
    );
endinterface

// File: rtl/memory_arbiter.sv
// Arbitrates one RAM port between instruction fetch and data access with
// bounded data priority (fairness) and an access timeout.
module memory_arbiter #(
    parameter int unsigned FAIR_LIMIT = 4,
    parameter int unsigned TIMEOUT    = 31
) (
    input  logic             CLK,
    input  logic             nRST,
    memory_arbiter_if.master bus
);
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned WAIT_W = 5;
    localparam int unsigned FAIR_W = (FAIR_LIMIT < 8) ? 3 : $clog2(FAIR_LIMIT + 1);

    localparam logic [1:0]        RAM_ACCESS = 2'd2;
    localparam logic [FAIR_W-1:0] FAIR_MAX   = FAIR_W'(FAIR_LIMIT);
    localparam logic [WAIT_W-1:0] WAIT_LAST  = WAIT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        IFETCH  = 2'd1,
        DACCESS = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [FAIR_W-1:0]   fair_q,  fair_d;
    logic [WAIT_W-1:0]   wait_q,  wait_d;
    logic [ADDR_W-1:0]   addr_q,  addr_d;
    logic [DATA_W-1:0]   store_q, store_d;
    logic                rd_q,    rd_d;
    logic                wr_q,    wr_d;

    logic d_req;
    logic gnt_d_first;
    logic gnt_i;
    logic gnt_d_late;

    // Grant priority: data while under the fairness limit, then fetch, then data.
    assign d_req       = bus.dREN | bus.dWEN;
    assign gnt_d_first = d_req && (fair_q < FAIR_MAX);
    assign gnt_i       = !gnt_d_first && bus.iREN;
    assign gnt_d_late  = !gnt_d_first && !bus.iREN && d_req;

    // State and latched-request registers.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= IDLE;
            fair_q  <= '0;
            wait_q  <= '0;
            addr_q  <= '0;
            store_q <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            fair_q  <= fair_d;
            wait_q  <= wait_d;
            addr_q  <= addr_d;
            store_q <= store_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
        end
    end

    // Next-state, grant latching and RAM/hit outputs.
    always_comb begin
        state_d      = state_q;
        fair_d       = fair_q;
        wait_d       = wait_q;
        addr_d       = addr_q;
        store_d      = store_q;
        rd_d         = rd_q;
        wr_d         = wr_q;
        bus.ramREN   = 1'b0;
        bus.ramWEN   = 1'b0;
        bus.ramaddr  = '0;
        bus.ramstore = '0;
        bus.ihit     = 1'b0;
        bus.iload    = '0;
        bus.dhit     = 1'b0;
        bus.dload    = '0;
        bus.err      = 1'b0;

        case (state_q)
            IDLE: begin
                wait_d = '0;
                if (gnt_d_first || gnt_d_late) begin
                    addr_d  = bus.daddr;
                    store_d = bus.dstore;
                    rd_d    = bus.dREN & ~bus.dWEN;
                    wr_d    = bus.dWEN;
                    state_d = DACCESS;
                end else if (gnt_i) begin
                    addr_d  = bus.iaddr;
                    store_d = '0;
                    rd_d    = 1'b1;
                    wr_d    = 1'b0;
                    state_d = IFETCH;
                end
                // Count data grants that bypass a waiting fetch.
                if (!bus.iREN || gnt_i) begin
                    fair_d = '0;
                end else if (gnt_d_first && (fair_q != FAIR_MAX)) begin
                    fair_d = fair_q + 1'b1;
                end
            end

            IFETCH, DACCESS: begin
                if ((state_q == IFETCH) && !bus.iREN) begin
                    // Fetch withdrawn (pipeline flush): drop strobes, no hit.
                    state_d = IDLE;
                    wait_d  = '0;
                end else begin
                    bus.ramREN   = rd_q;
                    bus.ramWEN   = wr_q;
                    bus.ramaddr  = addr_q;
                    bus.ramstore = store_q;
                    if (bus.ramstate == RAM_ACCESS) begin
                        if (state_q == IFETCH) begin
                            bus.ihit  = 1'b1;
                            bus.iload = bus.ramload;
                        end else begin
                            bus.dhit  = 1'b1;
                            bus.dload = bus.ramload;
                        end
                        state_d = IDLE;
                        wait_d  = '0;
                    end else if (wait_q == WAIT_LAST) begin
                        bus.err = 1'b1;
                        state_d = IDLE;
                        wait_d  = '0;
                    end else begin
                        wait_d = wait_q + 1'b1;
                    end
                end
            end

            default: begin
                state_d = IDLE;
                wait_d  = '0;
            end
        endcase
    end
endmodule

// File: tb/tb_memory_arbiter.sv
// Scoreboard bench for memory_arbiter: a transaction-level model predicts
// per-cycle RAM strobes, hit/err pulses and load data.
module tb_memory_arbiter;
    localparam int unsigned FAIR_LIMIT = 4;
    localparam int unsigned TIMEOUT    = 31;
    localparam logic [1:0]  RS_FREE    = 2'd0;
    localparam logic [1:0]  RS_BUSY    = 2'd1;
    localparam logic [1:0]  RS_ACCESS  = 2'd2;
    localparam logic [1:0]  RS_ERROR   = 2'd3;

    logic CLK;
    logic nRST;

    memory_arbiter_if bus();

    memory_arbiter #(
        .FAIR_LIMIT(FAIR_LIMIT),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .CLK (CLK),
        .nRST(nRST),
        .bus (bus)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    typedef struct {
        logic        ren;
        logic        wen;
        logic [31:0] addr;
        logic [31:0] store;
        logic        ihit;
        logic        dhit;
        logic        err;
    } cyc_exp_t;

    typedef struct {
        logic        is_instr;
        logic [31:0] load;
    } hit_exp_t;

    typedef struct {
        bit          is_instr;
        bit          rd;
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;
        int          waited;
    } txn_t;

    cyc_exp_t cyc_q[$];
    hit_exp_t hit_q[$];
    txn_t     act_q[$];
    int       fair;
    int       n_checks;
    int       n_fail;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    // Reference model: one cycle of arbitration seen at transaction level.
    task automatic model(input bit iren, input bit dren, input bit dwen,
                         input logic [31:0] ia, input logic [31:0] da,
                         input logic [31:0] ds, input logic [1:0] rs,
                         input logic [31:0] rl);
        cyc_exp_t e;
        txn_t     t;
        bit       dreq;
        bit       take_d;
        bit       take_i;
        e = '{ren: 1'b0, wen: 1'b0, addr: '0, store: '0, ihit: 1'b0, dhit: 1'b0, err: 1'b0};
        if (!nRST) begin
            act_q.delete();
            fair = 0;
        end else if (act_q.size() == 0) begin
            dreq   = dren | dwen;
            take_d = dreq && ((fair < int'(FAIR_LIMIT)) || !iren);
            take_i = iren && !take_d;
            if (take_d)
                act_q.push_back('{is_instr: 1'b0, rd: dren && !dwen, wr: dwen,
                                  addr: da, data: ds, waited: 0});
            else if (take_i)
                act_q.push_back('{is_instr: 1'b1, rd: 1'b1, wr: 1'b0,
                                  addr: ia, data: 32'h0, waited: 0});
            if (!iren || take_i) fair = 0;
            else if (take_d)     fair = (fair + 1 > int'(FAIR_LIMIT)) ? int'(FAIR_LIMIT) : fair + 1;
        end else begin
            t = act_q[0];
            if (t.is_instr && !iren) begin
                act_q.delete();
            end else begin
                e.ren   = t.rd;
                e.wen   = t.wr;
                e.addr  = t.addr;
                e.store = t.data;
                if (rs == RS_ACCESS) begin
                    if (t.is_instr) e.ihit = 1'b1;
                    else            e.dhit = 1'b1;
                    hit_q.push_back('{is_instr: t.is_instr, load: rl});
                    act_q.delete();
                end else begin
                    t.waited++;
                    if (t.waited == int'(TIMEOUT)) begin
                        e.err = 1'b1;
                        act_q.delete();
                    end else begin
                        act_q[0] = t;
                    end
                end
            end
        end
        cyc_q.push_back(e);
    endtask

    // Drive one cycle of stimulus and record the model's expectation.
    task automatic step(input bit iren, input bit dren, input bit dwen,
                        input logic [31:0] ia, input logic [31:0] da,
                        input logic [31:0] ds, input logic [1:0] rs,
                        input logic [31:0] rl);
        @(negedge CLK);
        bus.iREN     = iren;
        bus.dREN     = dren;
        bus.dWEN     = dwen;
        bus.iaddr    = ia;
        bus.daddr    = da;
        bus.dstore   = ds;
        bus.ramstate = rs;
        bus.ramload  = rl;
        model(iren, dren, dwen, ia, da, ds, rs, rl);
    endtask

    task automatic idle_step();
        step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, RS_FREE, 32'h0);
    endtask

    // Monitor: compares every cycle's outputs; pops load data on each hit.
    initial begin
        cyc_exp_t e;
        hit_exp_t h;
        forever begin
            @(negedge CLK);
            #3;
            if (cyc_q.size() != 0) begin
                e = cyc_q.pop_front();
                check("ramREN",   32'(bus.ramREN),   32'(e.ren));
                check("ramWEN",   32'(bus.ramWEN),   32'(e.wen));
                check("ramaddr",  bus.ramaddr,       e.addr);
                check("ramstore", bus.ramstore,      e.store);
                check("ihit",     32'(bus.ihit),     32'(e.ihit));
                check("dhit",     32'(bus.dhit),     32'(e.dhit));
                check("err",      32'(bus.err),      32'(e.err));
                if (bus.ihit || bus.dhit) begin
                    if (hit_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_hit: got ihit=%0b dhit=%0b expected none at %0t",
                                 bus.ihit, bus.dhit, $time);
                    end else begin
                        h = hit_q.pop_front();
                        check("hit_kind", 32'(bus.ihit), 32'(h.is_instr));
                        if (bus.ihit) check("iload", bus.iload, h.load);
                        else          check("dload", bus.dload, h.load);
                    end
                end
                if (!bus.ihit) check("iload_zero", bus.iload, 32'h0);
                if (!bus.dhit) check("dload_zero", bus.dload, 32'h0);
            end
        end
    end

    initial begin
        bit          iren_r;
        int          stuck_left;
        logic [1:0]  rs;
        n_checks = 0;
        n_fail   = 0;
        fair     = 0;
        nRST     = 1'b0;
        bus.iREN = 1'b0; bus.dREN = 1'b0; bus.dWEN = 1'b0;
        bus.iaddr = '0; bus.daddr = '0; bus.dstore = '0;
        bus.ramstate = RS_FREE; bus.ramload = '0;

        // Reset state, including a request held during reset.
        idle_step();
        step(1'b1, 1'b1, 1'b1, 32'h4, 32'h8, 32'hC, RS_ACCESS, 32'h55);
        idle_step();
        #4 nRST = 1'b1;
        idle_step();

        // Fetch with two RAM wait cycles.
        step(1'b1, 1'b0, 1'b0, 32'h40, 32'h0, 32'h0, RS_FREE,   32'h0);
        step(1'b1, 1'b0, 1'b0, 32'h40, 32'h0, 32'h0, RS_BUSY,   32'h0);
        step(1'b1, 1'b0, 1'b0, 32'h40, 32'h0, 32'h0, RS_BUSY,   32'h0);
        step(1'b1, 1'b0, 1'b0, 32'h40, 32'h0, 32'h0, RS_ACCESS, 32'h8C220004);
        idle_step();

        // Simultaneous fetch and write: write first, then fetch.
        step(1'b1, 1'b0, 1'b1, 32'h44, 32'h100, 32'hDEADBEEF, RS_FREE,   32'h0);
        step(1'b1, 1'b0, 1'b1, 32'h44, 32'h100, 32'hDEADBEEF, RS_ACCESS, 32'h0);
        step(1'b1, 1'b0, 1'b0, 32'h44, 32'h0,   32'h0,        RS_FREE,   32'h0);
        step(1'b1, 1'b0, 1'b0, 32'h44, 32'h0,   32'h0,        RS_ACCESS, 32'h12345678);
        idle_step();

        // Fairness: constant contention with an immediate RAM.
        for (int i = 0; i < 25; i++)
            step(1'b1, 1'b1, 1'b0, 32'h80 + 32'(i), 32'h200 + 32'(i), 32'h0, RS_ACCESS, $urandom);
        idle_step();

        // Data read against a stuck-busy RAM: timeout, then regrant.
        for (int i = 0; i < 35; i++)
            step(1'b0, 1'b1, 1'b0, 32'h0, 32'h300, 32'h0, RS_BUSY, 32'h0);
        idle_step();
        idle_step();

        // Fetch withdrawn mid-access.
        step(1'b1, 1'b0, 1'b0, 32'h90, 32'h0, 32'h0, RS_BUSY, 32'h0);
        step(1'b1, 1'b0, 1'b0, 32'h90, 32'h0, 32'h0, RS_BUSY, 32'h0);
        step(1'b0, 1'b0, 1'b0, 32'h90, 32'h0, 32'h0, RS_BUSY, 32'h0);
        idle_step();

        // Asynchronous reset during a write access.
        step(1'b0, 1'b0, 1'b1, 32'h0, 32'h400, 32'hCAFEF00D, RS_FREE, 32'h0);
        step(1'b0, 1'b0, 1'b1, 32'h0, 32'h400, 32'hCAFEF00D, RS_BUSY, 32'h0);
        #4 nRST = 1'b0;
        #1;
        check("async_ramWEN",   32'(bus.ramWEN), 32'h0);
        check("async_ramaddr",  bus.ramaddr,     32'h0);
        check("async_ramstore", bus.ramstore,    32'h0);
        idle_step();
        idle_step();
        #4 nRST = 1'b1;
        idle_step();
        idle_step();

        // Randomized traffic with occasional stuck-RAM stretches.
        iren_r     = 1'b0;
        stuck_left = 0;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(9) == 0) iren_r = ~iren_r;
            if (stuck_left > 0) stuck_left--;
            else if ($urandom_range(149) == 0) stuck_left = 40;
            if (stuck_left > 0)       rs = ($urandom_range(1) == 1) ? RS_BUSY : RS_ERROR;
            else if ($urandom_range(1) == 1) rs = RS_ACCESS;
            else                      rs = 2'($urandom_range(3));
            step(iren_r, 1'($urandom_range(1)), ($urandom_range(3) == 0),
                 $urandom, $urandom, $urandom, rs, $urandom);
        end
        idle_step();
        idle_step();

        @(negedge CLK);
        #5;
        check("cyc_queue_drained", 32'(cyc_q.size()), 32'h0);
        check("hit_queue_drained", 32'(hit_q.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/memory_arbiter.md
MEMORY_ARBITER -- requirements
Module: memory_arbiter

Interface
REQ-001 Parameter FAIR_LIMIT, default 4, is the max consecutive data grants while an instruction request waits.
REQ-002 Parameter TIMEOUT, default 31, is the max cycles in an access state before abort.
REQ-003 CLK  in  1  sole clock; all state updates on rising edge.
REQ-004 nRST  in  1  reset, asynchronous, active-low.
REQ-005 iREN  in  1  instruction fetch request.
REQ-006 iaddr  in  32  instruction word address.
REQ-007 ihit  out  1  one-cycle pulse: iload valid, fetch done.
REQ-008 iload  out  32  fetched instruction.
REQ-009 dREN  in  1  data read request.
REQ-010 dWEN  in  1  data write request; dREN and dWEN both high is a write.
REQ-011 daddr  in  32  data address.
REQ-012 dstore  in  32  store data.
REQ-013 dhit  out  1  one-cycle pulse: data access done.
REQ-014 dload  out  32  load data.
REQ-015 ramREN  out  1  RAM read strobe.
REQ-016 ramWEN  out  1  RAM write strobe.
REQ-017 ramaddr  out  32  RAM address.
REQ-018 ramstore  out  32  RAM write data.
REQ-019 ramload  in  32  RAM read data.
REQ-020 ramstate  in  2  RAM status: FREE=0, BUSY=1, ACCESS=2, ERROR=3.
REQ-021 err  out  1  one-cycle pulse on timeout abort.

Function
REQ-022 FSM states IDLE, IFETCH, DACCESS; exactly one state active.
REQ-023 IDLE: ramREN=ramWEN=0, no hits; grant evaluated each cycle.
REQ-024 Grant rule: (dREN|dWEN) and fair_cnt<FAIR_LIMIT -> DACCESS; else iREN -> IFETCH; else (dREN|dWEN) -> DACCESS; else stay IDLE.
REQ-025 On grant, latch address, store data and op (read/write) into internal regs; RAM outputs driven only from latched regs.
REQ-026 fair_cnt (3+ bits, saturating at FAIR_LIMIT): +1 on data grant while iREN high; cleared on instruction grant or when iREN low in IDLE.
REQ-027 IFETCH: ramREN=1, ramWEN=0, ramaddr=latched iaddr.
REQ-028 DACCESS: ramREN=latched read, ramWEN=latched write, ramaddr=latched daddr, ramstore=latched dstore.
REQ-029 In access state with ramstate==ACCESS: assert matching hit combinationally that cycle, iload/dload=ramload, next state IDLE.
REQ-030 Hit latency from grant = RAM wait cycles + 1; minimum 1 cycle after entering access state (no same-cycle hit in IDLE).
REQ-031 ramstate ERROR or BUSY or FREE: hold state, keep strobes, increment wait counter.
REQ-032 Wait counter (5 bits) cleared on state entry; reaching TIMEOUT without ACCESS -> err=1 one cycle, no hit, next IDLE.
REQ-033 ACCESS and TIMEOUT in same cycle: ACCESS wins, hit asserted, err=0.
REQ-034 IFETCH abort: iREN low in IFETCH -> strobes 0 that cycle, no ihit, next IDLE (pipeline flush); DACCESS never aborts.
REQ-035 ihit and dhit never high in same cycle; hits never high in IDLE.
REQ-036 iload/dload read as 0 whenever the corresponding hit is low.

Reset
REQ-037 nRST low: state=IDLE, fair_cnt=0, wait counter=0, latched regs=0, immediately and asynchronously.
REQ-038 While nRST low and first cycle after: ramREN=ramWEN=0, ihit=dhit=err=0, iload=dload=ramaddr=ramstore=0.
REQ-039 Reset mid-access drops strobes asynchronously; no hit for the aborted access.

Verification
REQ-040 iREN=1, iaddr=0x40, ramstate ACCESS after 2 cycles, ramload=0x8C220004 -> ramREN on for 3 cycles, ihit one cycle, iload=0x8C220004.
REQ-041 iREN=1 and dWEN=1, daddr=0x100, dstore=0xDEADBEEF same cycle -> DACCESS first, ramWEN=1, ramstore=0xDEADBEEF, dhit, then IFETCH.
REQ-042 dREN and iREN held high, RAM immediate -> 4 dhits then 1 ihit, pattern repeats; fair_cnt never exceeds 4.
REQ-043 dREN=1, ramstate stuck BUSY -> err pulse after 31 cycles in DACCESS, no dhit, back to IDLE, regrant next cycle.
REQ-044 IFETCH with iREN dropped after 1 cycle -> no ihit, ramREN=0 that cycle, IDLE next.
REQ-045 nRST asserted during DACCESS with ramWEN=1 -> ramWEN=0 without clock edge; after release, IDLE with all outputs 0.
